mem_stage: RTL

Memory stage of the five-stage pipelined MIPS CPU, fed directly by the Execute-to-Memory pipeline register and producing the Memory-to-Writeback register outputs. It performs data-memory loads and stores over a req/ack bus, stalls the upstream pipeline while an access is outstanding, and aborts accesses that exceed a bounded wait. Non-memory instructions pass through in one cycle.

---
 rtl/mips_pkg.sv | 29 ++
 rtl/mem_stage_if.sv | 26 ++
 rtl/mtow_reg.sv | 32 +++
 rtl/mem_stage.sv | 138 +++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline memory stage: FSM states, widths,
// and the Memory-to-Writeback payload.
package mips_pkg;

  localparam int REG_ADDR_W      = 5;
  localparam int DATA_W          = 32;
  localparam int DEFAULT_TIMEOUT = 16;
  localparam int CNT_W           = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  typedef struct packed {
    logic                  reg_write;
    logic                  mem_to_reg;
    logic                  bus_err;
    logic [DATA_W-1:0]     read_data;
    logic [DATA_W-1:0]     alu_out;
    logic [REG_ADDR_W-1:0] write_reg;
  } w_bundle_t;

  function automatic logic is_mem_op(input logic mem_to_reg, input logic mem_write);
    return mem_to_reg | mem_write;
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory req/ack bus between the memory stage (master) and the data
// memory (slave).
interface mem_stage_if
  import mips_pkg::*;
#(
  parameter int ADDR_W = 32
);

  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic [DATA_W-1:0] dmem_rdata;
  logic              dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_ack
  );

endinterface

// File: rtl/mtow_reg.sv
// Memory-to-Writeback pipeline register. A bubble clears the control bits and
// keeps the data fields; reset is synchronous.
module mtow_reg
  import mips_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      i_load,
  input  logic      i_bubble,
  input  w_bundle_t i_d,
  output w_bundle_t o_q
);

  w_bundle_t r_q;

  // NOTE: registered state is always assigned with <= so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else if (i_bubble) begin
      r_q.reg_write  <= 1'b0;
      r_q.mem_to_reg <= 1'b0;
      r_q.bus_err    <= 1'b0;
    end else if (i_load) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/mem_stage.sv
// MIPS memory stage: req/ack data-memory access with bounded wait, upstream
// stall, and the M->W register. Optional macro MEM_ALIGN_CHECK_EN aborts
// misaligned accesses without issuing a request.
module mem_stage
  import mips_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int ADDR_W  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RegWriteM,
  input  logic                  MemtoRegM,
  input  logic                  MemWriteM,
  input  logic [DATA_W-1:0]     ALUOutM,
  input  logic [DATA_W-1:0]     WriteDataM,
  input  logic [REG_ADDR_W-1:0] WriteRegM,
  mem_stage_if.master           dmem,
  output logic                  StallM,
  output logic                  RegWriteW,
  output logic                  MemtoRegW,
  output logic [DATA_W-1:0]     ReadDataW,
  output logic [DATA_W-1:0]     ALUOutW,
  output logic [REG_ADDR_W-1:0] WriteRegW,
  output logic                  BusErrW
);

  localparam logic [CNT_W-1:0] L_LAST_WAIT = CNT_W'(TIMEOUT - 1);

  mem_state_t        r_state;
  logic              r_req;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_abort;

  logic      w_mem_op;
  logic      w_misaligned;
  logic      w_done;
  logic      w_abort;
  w_bundle_t w_next;
  w_bundle_t w_q;

  assign w_mem_op = is_mem_op(MemtoRegM, MemWriteM);
  assign w_done   = (r_state == DONE);
  assign w_abort  = w_done & r_abort;
  assign StallM   = w_mem_op & ~w_done;

`ifdef MEM_ALIGN_CHECK_EN
  assign w_misaligned = |ALUOutM[1:0];
`else
  assign w_misaligned = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_cnt   <= '0;
      r_abort <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_mem_op && w_misaligned) begin
            r_state <= DONE;
            r_abort <= 1'b1;
          end else if (w_mem_op) begin
            r_state <= BUSY;
            r_req   <= 1'b1;
            r_we    <= MemWriteM;   // a load+store pair is handled as a store
            r_addr  <= ADDR_W'(ALUOutM);
            r_wdata <= WriteDataM;
            r_cnt   <= '0;
            r_abort <= 1'b0;
          end
        end
        BUSY: begin
          // ack has priority over the final wait cycle
          if (dmem.dmem_ack) begin
            r_state <= DONE;
            r_req   <= 1'b0;
            r_rdata <= dmem.dmem_rdata;
          end else if (r_cnt == L_LAST_WAIT) begin
            r_state <= DONE;
            r_req   <= 1'b0;
            r_abort <= 1'b1;
          end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign dmem.dmem_req   = r_req;
  assign dmem.dmem_we    = r_we;
  assign dmem.dmem_addr  = r_addr;
  assign dmem.dmem_wdata = r_wdata;

  always_comb begin
    // NOTE: a default for the whole struct first keeps every path assigned,
    // so no latch is inferred.
    w_next            = '0;
    w_next.reg_write  = RegWriteM & ~w_abort;
    w_next.mem_to_reg = MemtoRegM;
    w_next.bus_err    = w_abort;
    w_next.alu_out    = ALUOutM;
    w_next.write_reg  = WriteRegM;
    if (w_done && !r_abort && !MemWriteM) begin
      w_next.read_data = r_rdata;
    end
  end

  mtow_reg u_mtow_reg (
    .clk      (clk),
    .rst      (rst),
    .i_load   (1'b1),
    .i_bubble (StallM),
    .i_d      (w_next),
    .o_q      (w_q)
  );

  assign RegWriteW = w_q.reg_write;
  assign MemtoRegW = w_q.mem_to_reg;
  assign BusErrW   = w_q.bus_err;
  assign ReadDataW = w_q.read_data;
  assign ALUOutW   = w_q.alu_out;
  assign WriteRegW = w_q.write_reg;

endmodule
